// File: rtl/vector_check_pkg.sv
// Shared types for the hardware response checker: FSM state encoding and the
// delay-line entry that carries one expected word toward its comparison point.
package vector_check_pkg;

  // Widest compared word the delay-line entry can carry. Wrappers use the low DATA_W bits.
  localparam int EXP_DATA_MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } chk_state_e;

  typedef struct packed {
    logic                      valid;
    logic                      last;
    logic [EXP_DATA_MAX_W-1:0] data;
  } exp_entry_s;

endpackage

// File: rtl/exp_delay_line.sv
// LATENCY-stage shift register of expected-word entries. It has a synchronous
// clear and an asynchronous active-low reset, and is a pass-through when LATENCY is 0.
module exp_delay_line
  import vector_check_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  exp_entry_s in_entry,
  output exp_entry_s out_entry
);

  generate
    if (LATENCY == 0) begin : g_pass
      logic unused_ports;
      assign unused_ports = clk ^ rst_n ^ clr;
      assign out_entry    = in_entry;
    end else begin : g_pipe
      exp_entry_s pipe_q [LATENCY];
      exp_entry_s pipe_d [LATENCY];

      always_comb begin
        pipe_d[0] = in_entry;
        for (int i = 1; i < LATENCY; i++) pipe_d[i] = pipe_q[i-1];
        if (clr) begin
          for (int i = 0; i < LATENCY; i++) pipe_d[i] = '0;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
        end else begin
          for (int i = 0; i < LATENCY; i++) pipe_q[i] <= pipe_d[i];
        end
      end

      assign out_entry = pipe_q[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/vector_checker.sv
// Hardware response checker. It delays expected words by the DUT latency, compares
// them with the DUT output, and keeps the error count and the first-mismatch capture.
module vector_checker
  import vector_check_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int LATENCY = 1,
  parameter int IDX_W   = 8,
  parameter int ERR_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_exp_valid,
  input  logic [DATA_W-1:0] i_exp_data,
  input  logic              i_exp_last,
  input  logic [DATA_W-1:0] i_dut_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_overflow,
  output logic [IDX_W-1:0]  o_vec_count,
  output logic [ERR_W-1:0]  o_err_count,
  output logic [IDX_W-1:0]  o_first_err_idx,
  output logic [DATA_W-1:0] o_first_err_exp,
  output logic [DATA_W-1:0] o_first_err_got,
  output logic [1:0]        o_state
);

  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  chk_state_e        state_q, state_d;
  logic [IDX_W-1:0]  vec_count_q, vec_count_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [IDX_W-1:0]  first_idx_q, first_idx_d;
  logic [DATA_W-1:0] first_exp_q, first_exp_d;
  logic [DATA_W-1:0] first_got_q, first_got_d;
  logic              overflow_q, overflow_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  exp_entry_s push_entry, cmp_entry;
  logic       start_fire, clr, cmp_fire, mismatch, wrap;
  logic       unused_hi;

  // Expected words are only accepted in RUN; every other cycle shifts in a bubble.
  always_comb begin
    start_fire = i_start && ((state_q == IDLE) || (state_q == DONE));
    push_entry = '0;
    if ((state_q == RUN) && i_exp_valid) begin
      push_entry.valid             = 1'b1;
      push_entry.last              = i_exp_last;
      push_entry.data[DATA_W-1:0]  = i_exp_data;
    end
  end

  exp_delay_line #(.LATENCY(LATENCY)) u_delay (
    .clk       (i_clk),
    .rst_n     (i_reset),
    .clr       (clr),
    .in_entry  (push_entry),
    .out_entry (cmp_entry)
  );

  assign unused_hi = ^cmp_entry.data;

  always_comb begin
    state_d     = state_q;
    vec_count_d = vec_count_q;
    err_count_d = err_count_q;
    first_idx_d = first_idx_q;
    first_exp_d = first_exp_q;
    first_got_d = first_got_q;
    overflow_d  = overflow_q;
    cmp_fire    = cmp_entry.valid && ((state_q == RUN) || (state_q == DRAIN));
    mismatch    = cmp_fire && (cmp_entry.data[DATA_W-1:0] != i_dut_data);
    wrap        = cmp_fire && (vec_count_q == '1);
    // A wrap abandons whatever is still in flight.
    clr         = start_fire || wrap;

    if (start_fire) begin
      state_d     = RUN;
      vec_count_d = '0;
      err_count_d = '0;
      first_idx_d = '0;
      first_exp_d = '0;
      first_got_d = '0;
      overflow_d  = 1'b0;
    end else begin
      if (cmp_fire) vec_count_d = vec_count_q + IDX_ONE;
      if (mismatch) begin
        if (err_count_q != '1) err_count_d = err_count_q + ERR_ONE;
        // Saturating counter is still zero only before the first mismatch.
        if (err_count_q == '0) begin
          first_idx_d = vec_count_q;
          first_exp_d = cmp_entry.data[DATA_W-1:0];
          first_got_d = i_dut_data;
        end
      end
      if (wrap) begin
        overflow_d = 1'b1;
        state_d    = DONE;
      end else if (cmp_fire && cmp_entry.last) begin
        state_d = DONE;
      end else if ((state_q == RUN) && push_entry.valid && push_entry.last) begin
        state_d = DRAIN;
      end
    end

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_count_d == '0) && !overflow_d;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      vec_count_q <= '0;
      err_count_q <= '0;
      first_idx_q <= '0;
      first_exp_q <= '0;
      first_got_q <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_count_q <= vec_count_d;
      err_count_q <= err_count_d;
      first_idx_q <= first_idx_d;
      first_exp_q <= first_exp_d;
      first_got_q <= first_got_d;
      overflow_q  <= overflow_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  assign o_busy          = busy_q;
  assign o_done          = done_q;
  assign o_pass          = pass_q;
  assign o_overflow      = overflow_q;
  assign o_vec_count     = vec_count_q;
  assign o_err_count     = err_count_q;
  assign o_first_err_idx = first_idx_q;
  assign o_first_err_exp = first_exp_q;
  assign o_first_err_got = first_got_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench for vector_checker: four instances (latency 0/1/2 and a 3-bit index)
// share one stimulus stream; the DUT word is the expected word delayed and optionally corrupted.
module tb_vector_checker;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_start = 1'b0;
  logic       i_exp_valid = 1'b0;
  logic [3:0] i_exp_data = 4'h0;
  logic       i_exp_last = 1'b0;
  logic [3:0] got_now = 4'h0;
  logic [3:0] g1 = 4'h0;
  logic [3:0] g2 = 4'h0;
  int         n_checks = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  // DUT-side word stream: got_now is what a latency-L DUT would emit L cycles later.
  always @(posedge clk) begin
    g1 <= got_now;
    g2 <= g1;
  end

  logic       l1_busy, l1_done, l1_pass, l1_ovf;
  logic [7:0] l1_cnt, l1_fidx;
  logic [15:0] l1_err;
  logic [3:0] l1_fexp, l1_fgot;
  logic [1:0] l1_st;
  logic       l2_busy, l2_done, l2_pass, l2_ovf;
  logic [7:0] l2_cnt, l2_fidx;
  logic [15:0] l2_err;
  logic [3:0] l2_fexp, l2_fgot;
  logic [1:0] l2_st;
  logic       l0_busy, l0_done, l0_pass, l0_ovf;
  logic [7:0] l0_cnt, l0_fidx;
  logic [15:0] l0_err;
  logic [3:0] l0_fexp, l0_fgot;
  logic [1:0] l0_st;
  logic       ix_busy, ix_done, ix_pass, ix_ovf;
  logic [2:0] ix_cnt, ix_fidx;
  logic [15:0] ix_err;
  logic [3:0] ix_fexp, ix_fgot;
  logic [1:0] ix_st;

  vector_checker #(.DATA_W(4), .LATENCY(1), .IDX_W(8), .ERR_W(16)) u_l1 (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_exp_valid(i_exp_valid),
    .i_exp_data(i_exp_data), .i_exp_last(i_exp_last), .i_dut_data(g1),
    .o_busy(l1_busy), .o_done(l1_done), .o_pass(l1_pass), .o_overflow(l1_ovf),
    .o_vec_count(l1_cnt), .o_err_count(l1_err), .o_first_err_idx(l1_fidx),
    .o_first_err_exp(l1_fexp), .o_first_err_got(l1_fgot), .o_state(l1_st));

  vector_checker #(.DATA_W(4), .LATENCY(2), .IDX_W(8), .ERR_W(16)) u_l2 (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_exp_valid(i_exp_valid),
    .i_exp_data(i_exp_data), .i_exp_last(i_exp_last), .i_dut_data(g2),
    .o_busy(l2_busy), .o_done(l2_done), .o_pass(l2_pass), .o_overflow(l2_ovf),
    .o_vec_count(l2_cnt), .o_err_count(l2_err), .o_first_err_idx(l2_fidx),
    .o_first_err_exp(l2_fexp), .o_first_err_got(l2_fgot), .o_state(l2_st));

  vector_checker #(.DATA_W(4), .LATENCY(0), .IDX_W(8), .ERR_W(16)) u_l0 (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_exp_valid(i_exp_valid),
    .i_exp_data(i_exp_data), .i_exp_last(i_exp_last), .i_dut_data(got_now),
    .o_busy(l0_busy), .o_done(l0_done), .o_pass(l0_pass), .o_overflow(l0_ovf),
    .o_vec_count(l0_cnt), .o_err_count(l0_err), .o_first_err_idx(l0_fidx),
    .o_first_err_exp(l0_fexp), .o_first_err_got(l0_fgot), .o_state(l0_st));

  vector_checker #(.DATA_W(4), .LATENCY(1), .IDX_W(3), .ERR_W(16)) u_ix (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_exp_valid(i_exp_valid),
    .i_exp_data(i_exp_data), .i_exp_last(i_exp_last), .i_dut_data(g1),
    .o_busy(ix_busy), .o_done(ix_done), .o_pass(ix_pass), .o_overflow(ix_ovf),
    .o_vec_count(ix_cnt), .o_err_count(ix_err), .o_first_err_idx(ix_fidx),
    .o_first_err_exp(ix_fexp), .o_first_err_got(ix_fgot), .o_state(ix_st));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic start_run();
    i_start = 1'b1;
    i_exp_valid = 1'b0;
    i_exp_last = 1'b0;
    tick();
    i_start = 1'b0;
  endtask

  task automatic send(input logic v, input logic [3:0] d, input logic l, input logic [3:0] corrupt);
    i_exp_valid = v;
    i_exp_data = d;
    i_exp_last = l;
    got_now = d ^ corrupt;
    tick();
    i_exp_valid = 1'b0;
    i_exp_last = 1'b0;
  endtask

  initial begin
    // Reset values
    tick();
    check("rst_state", l1_st, 0);
    check("rst_busy", l1_busy, 0);
    check("rst_done", l1_done, 0);
    check("rst_pass", l1_pass, 0);
    check("rst_ovf", l1_ovf, 0);
    check("rst_cnt", l1_cnt, 0);
    check("rst_err", l1_err, 0);
    check("rst_fidx", l1_fidx, 0);
    i_reset = 1'b1;
    tick();

    // Latency 1: eight matching vectors, DONE exactly one cycle after last is accepted
    start_run();
    check("t1_busy_after_start", l1_busy, 1);
    for (int i = 0; i < 8; i++) send(1'b1, 4'(i), (i == 7), 4'h0);
    check("t1_state_drain", l1_st, 2);
    check("t1_not_done_yet", l1_done, 0);
    tick();
    check("t1_done", l1_done, 1);
    check("t1_busy_low", l1_busy, 0);
    check("t1_count", l1_cnt, 8);
    check("t1_err", l1_err, 0);
    check("t1_pass", l1_pass, 1);
    tick();

    // Latency 2: vector 3 comes back as B, vector 6 as 7
    start_run();
    for (int i = 0; i < 8; i++)
      send(1'b1, 4'(i), (i == 7), (i == 3) ? 4'h8 : ((i == 6) ? 4'h1 : 4'h0));
    tick();
    check("t2_not_done_lat2", l2_done, 0);
    tick();
    check("t2_done", l2_done, 1);
    check("t2_count", l2_cnt, 8);
    check("t2_err", l2_err, 2);
    check("t2_first_idx", l2_fidx, 3);
    check("t2_first_exp", l2_fexp, 4'h3);
    check("t2_first_got", l2_fgot, 4'hB);
    check("t2_pass", l2_pass, 0);

    // Latency 1 with bubbles between vectors; bubble words would mismatch if compared
    start_run();
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 4'(i + 4), (i == 4), 4'h0);
      if (i != 4) send(1'b0, 4'hF, 1'b0, 4'h5);
    end
    tick();
    tick();
    check("t3_done", l1_done, 1);
    check("t3_count", l1_cnt, 5);
    check("t3_err", l1_err, 0);
    check("t3_pass", l1_pass, 1);
    check("t3_l2_count", l2_cnt, 5);
    check("t3_l2_err", l2_err, 0);

    // 3-bit index: nine vectors without last wrap the count
    start_run();
    for (int i = 0; i < 9; i++) send(1'b1, 4'(i), 1'b0, 4'h0);
    check("t4_overflow", ix_ovf, 1);
    check("t4_done", ix_done, 1);
    check("t4_pass", ix_pass, 0);
    check("t4_count_wrapped", ix_cnt, 0);
    tick();
    check("t4_count_held", ix_cnt, 0);
    check("t4_err_after_discard", ix_err, 0);

    // Reset mid-run, then reset while latency-2 instance is draining
    i_reset = 1'b0;
    #1;
    check("t5_abort_busy", l1_busy, 0);
    check("t5_abort_cnt", l1_cnt, 0);
    @(negedge clk);
    i_reset = 1'b1;
    tick();
    start_run();
    send(1'b1, 4'h1, 1'b0, 4'h0);
    send(1'b1, 4'h2, 1'b0, 4'h4);
    send(1'b1, 4'h3, 1'b1, 4'h0);
    check("t5_in_drain", l2_st, 2);
    check("t5_err_before_rst", l2_err, 0);
    check("t5_cnt_before_rst", l2_cnt, 1);
    i_reset = 1'b0;
    #1;
    check("t5_rst_state", l2_st, 0);
    check("t5_rst_busy", l2_busy, 0);
    check("t5_rst_done", l2_done, 0);
    check("t5_rst_pass", l2_pass, 0);
    check("t5_rst_cnt", l2_cnt, 0);
    check("t5_rst_err", l2_err, 0);
    check("t5_rst_fgot", l2_fgot, 0);
    @(negedge clk);
    i_reset = 1'b1;
    tick();
    start_run();
    send(1'b1, 4'h5, 1'b0, 4'h0);
    send(1'b1, 4'h6, 1'b0, 4'h0);
    send(1'b1, 4'h7, 1'b1, 4'h0);
    tick();
    tick();
    check("t5_rerun_done", l2_done, 1);
    check("t5_rerun_pass", l2_pass, 1);
    check("t5_rerun_cnt", l2_cnt, 3);

    // Latency 0: last on first vector (mismatched), then restart in DONE with a coincident valid
    start_run();
    send(1'b1, 4'hA, 1'b1, 4'h3);
    check("t6_done_next", l0_done, 1);
    check("t6_cnt", l0_cnt, 1);
    check("t6_err", l0_err, 1);
    check("t6_fidx", l0_fidx, 0);
    check("t6_fexp", l0_fexp, 4'hA);
    check("t6_fgot", l0_fgot, 4'h9);
    check("t6_pass", l0_pass, 0);
    tick();
    tick();
    check("t6_held_fgot", l0_fgot, 4'h9);
    i_start = 1'b1;
    i_exp_valid = 1'b1;
    i_exp_data = 4'h5;
    i_exp_last = 1'b1;
    got_now = 4'h0;
    tick();
    i_start = 1'b0;
    i_exp_valid = 1'b0;
    i_exp_last = 1'b0;
    check("t6_restart_busy", l0_busy, 1);
    check("t6_restart_done", l0_done, 0);
    check("t6_restart_cnt", l0_cnt, 0);
    check("t6_restart_err", l0_err, 0);
    check("t6_restart_fgot", l0_fgot, 0);
    send(1'b1, 4'h2, 1'b0, 4'h0);
    send(1'b1, 4'h9, 1'b1, 4'h0);
    check("t6_run2_done", l0_done, 1);
    check("t6_run2_cnt", l0_cnt, 2);
    check("t6_run2_pass", l0_pass, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
